// File: rtl/wtu_pkg.sv
// Shared definitions for the forward and inverse Haar wavelet stages:
// default coefficient width, inverse-stage FSM encoding and saturation bounds.
package wtu_pkg;

    localparam int unsigned WTU_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OUT_A = 2'd1,
        OUT_B = 2'd2
    } iwtu_state_t;

    // Two's-complement limits at the default width
    localparam logic signed [WTU_WIDTH-1:0] WTU_SAT_MAX = {1'b0, {(WTU_WIDTH-1){1'b1}}};
    localparam logic signed [WTU_WIDTH-1:0] WTU_SAT_MIN = {1'b1, {(WTU_WIDTH-1){1'b0}}};

endpackage

// File: rtl/iwtu_recon.sv
// Combinational Haar reconstruction: saturated lp+hp and lp-hp with clip flags.
module iwtu_recon
    import wtu_pkg::*;
#(
    parameter int unsigned WIDTH = WTU_WIDTH
) (
    input  logic signed [WIDTH-1:0] i_lp,
    input  logic signed [WIDTH-1:0] i_hp,
    output logic signed [WIDTH-1:0] o_sum,
    output logic signed [WIDTH-1:0] o_diff,
    output logic                    o_sum_clip,
    output logic                    o_diff_clip
);

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0] w_lp_ext;
    logic signed [WIDTH:0] w_hp_ext;
    logic signed [WIDTH:0] w_sum_ext;
    logic signed [WIDTH:0] w_diff_ext;

    assign w_lp_ext   = {i_lp[WIDTH-1], i_lp};
    assign w_hp_ext   = {i_hp[WIDTH-1], i_hp};
    assign w_sum_ext  = w_lp_ext + w_hp_ext;
    assign w_diff_ext = w_lp_ext - w_hp_ext;

    // One guard bit suffices: overflow shows as the top two bits disagreeing
    assign o_sum_clip  = w_sum_ext[WIDTH] ^ w_sum_ext[WIDTH-1];
    assign o_diff_clip = w_diff_ext[WIDTH] ^ w_diff_ext[WIDTH-1];

    assign o_sum  = o_sum_clip  ? (w_sum_ext[WIDTH]  ? SAT_MIN : SAT_MAX) : w_sum_ext[WIDTH-1:0];
    assign o_diff = o_diff_clip ? (w_diff_ext[WIDTH] ? SAT_MIN : SAT_MAX) : w_diff_ext[WIDTH-1:0];

endmodule

// File: rtl/iwtu_stream.sv
// Streaming inverse Haar unit: accepts (lp,hp) pairs and emits lp+hp then lp-hp
// serially on a registered valid/ready port, with a sticky saturation flag.
module iwtu_stream
    import wtu_pkg::*;
#(
    parameter int unsigned WIDTH = WTU_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] lp,
    input  logic signed [WIDTH-1:0] hp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_sample,
    output logic                    out_first,
    output logic                    sat
);

    iwtu_state_t r_state, w_state_nxt;

    logic signed [WIDTH-1:0] r_sample, w_sample_nxt;
    logic signed [WIDTH-1:0] r_hold,   w_hold_nxt;
    logic                    r_valid,  w_valid_nxt;
    logic                    r_first,  w_first_nxt;
    logic                    r_sat,    w_sat_nxt;

    logic signed [WIDTH-1:0] w_sum;
    logic signed [WIDTH-1:0] w_diff;
    logic                    w_sum_clip;
    logic                    w_diff_clip;
    logic                    w_accept;

    iwtu_recon #(
        .WIDTH (WIDTH)
    ) u_recon (
        .i_lp        (lp),
        .i_hp        (hp),
        .o_sum       (w_sum),
        .o_diff      (w_diff),
        .o_sum_clip  (w_sum_clip),
        .o_diff_clip (w_diff_clip)
    );

    // OUT_B bypass lets a new pair land in the same cycle B is consumed
    assign in_ready = !rst && ((r_state == IDLE) || ((r_state == OUT_B) && out_ready));
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample;
        w_hold_nxt   = r_hold;
        w_valid_nxt  = r_valid;
        w_first_nxt  = r_first;
        w_sat_nxt    = r_sat || (w_accept && (w_sum_clip || w_diff_clip));

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = OUT_A;
                    w_sample_nxt = w_sum;
                    w_hold_nxt   = w_diff;
                    w_valid_nxt  = 1'b1;
                    w_first_nxt  = 1'b1;
                end
            end
            OUT_A: begin
                if (out_ready) begin
                    w_state_nxt  = OUT_B;
                    w_sample_nxt = r_hold;
                    w_first_nxt  = 1'b0;
                end
            end
            OUT_B: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_nxt  = OUT_A;
                        w_sample_nxt = w_sum;
                        w_hold_nxt   = w_diff;
                        w_first_nxt  = 1'b1;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_valid_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_first_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sample <= '0;
            r_hold   <= '0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sample <= w_sample_nxt;
            r_hold   <= w_hold_nxt;
            r_valid  <= w_valid_nxt;
            r_first  <= w_first_nxt;
            r_sat    <= w_sat_nxt;
        end
    end

    assign out_valid  = r_valid;
    assign out_sample = r_sample;
    assign out_first  = r_first;
    assign sat        = r_sat;

endmodule
